// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bundle: instruction-memory handshake, redirect/stall from
// downstream, and the FIFO head presented to decode.
`timescale 1ns/1ps
interface fetch_queue_stage_if #(
    parameter int ISIZE = 16,
    parameter int DSIZE = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             imem_req;
    logic [ISIZE-1:0] imem_addr;
    logic             imem_ack;
    logic [DSIZE-1:0] imem_rdata;
    logic             redirect;
    logic [ISIZE-1:0] redirect_pc;
    logic             stall;
    logic             inst_valid;
    logic [DSIZE-1:0] inst;
    logic [ISIZE-1:0] inst_pc;
    logic [CW-1:0]    fifo_count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, fifo_count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, fifo_count,
        output imem_ack, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the fetch PC, requests words from imem and
// queues {pc, inst} pairs for decode; redirects flush and restart fetch.
`timescale 1ns/1ps
module fetch_queue_stage #(
    parameter int               ISIZE    = 16,
    parameter int               DSIZE    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [ISIZE-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    fetch_queue_stage_if.master bus
);
    // state | meaning
    // IDLE  | no request; FIFO full (or just out of reset)
    // REQ   | request at fetch_pc outstanding
    // DROP  | completing an abandoned request at drop_addr; data discarded

    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t           state, state_nxt;
    logic [ISIZE-1:0] fetch_pc, fetch_pc_nxt;
    logic [ISIZE-1:0] drop_addr, drop_addr_nxt;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_after;
    logic             push, pop, flush;

    logic [DSIZE-1:0] mem_inst [DEPTH];
    logic [ISIZE-1:0] mem_pc   [DEPTH];

    assign pop         = (count != '0) && !bus.stall && !bus.redirect;
    assign count_after = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        drop_addr_nxt = drop_addr;
        push          = 1'b0;
        flush         = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = bus.redirect_pc;
                    state_nxt    = REQ;
                end else if (count < FULL) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = bus.redirect_pc;
                    if (!bus.imem_ack) begin
                        drop_addr_nxt = fetch_pc;
                        state_nxt     = DROP;
                    end
                end else if (bus.imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + ISIZE'(1);
                    state_nxt    = (count_after < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                // an ack coinciding with a fresh redirect still retires the old request
                if (bus.redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            drop_addr <= drop_addr_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign bus.imem_req   = (state != IDLE);
    assign bus.imem_addr  = (state == DROP) ? drop_addr : fetch_pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = mem_inst[rd_ptr];
    assign bus.inst_pc    = mem_pc[rd_ptr];
    assign bus.fifo_count = count;
endmodule
